// File: rtl/three_operand_accum_ctrl.sv
// Burst accumulator controller that drives a shared external three-operand adder.
// Optional exact-sum cross-check is compiled in with `define AXPPA_EXACT_CHECK_EN.
module three_operand_accum_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_op0,
  input  logic [WIDTH-1:0] in_op1,
  input  logic             in_op1_en,
  input  logic             in_last,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic [WIDTH-1:0] add_c,
  input  logic [WIDTH-1:0] add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic [CNT_W-1:0] beat_count,
  output logic             count_sat,
  output logic             mismatch
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Handshakes: a beat transfers on a cycle where in_valid && in_ready; a result
  // transfers on a cycle where out_valid && out_ready. Neither side may depend on
  // the other's ready to raise valid.
  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic             fire;
  logic             result_taken;
  logic             cnt_full;

  assign in_ready     = !reset && (state != S_DONE);
  assign fire         = in_valid && in_ready;
  assign result_taken = out_valid && out_ready;
  assign cnt_full     = (beat_count == {CNT_W{1'b1}});

  assign add_a = acc;
  assign add_b = fire ? in_op0 : '0;
  assign add_c = (fire && in_op1_en) ? in_op1 : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      acc        <= '0;
      out_valid  <= 1'b0;
      sum_out    <= '0;
      beat_count <= '0;
      count_sat  <= 1'b0;
    end else if (flush) begin
      // A beat presented alongside flush is handshaken but discarded.
      state      <= S_IDLE;
      acc        <= '0;
      out_valid  <= 1'b0;
      beat_count <= '0;
      count_sat  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ACCUM: begin
          if (fire) begin
            acc <= add_sum;
            if (cnt_full) count_sat  <= 1'b1;
            else          beat_count <= beat_count + 1'b1;
            if (in_last) begin
              state     <= S_DONE;
              sum_out   <= add_sum;
              out_valid <= 1'b1;
            end else begin
              state <= S_ACCUM;
            end
          end
        end
        S_DONE: begin
          if (result_taken) begin
            state      <= S_IDLE;
            acc        <= '0;
            out_valid  <= 1'b0;
            beat_count <= '0;
            count_sat  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef AXPPA_EXACT_CHECK_EN
  logic [WIDTH-1:0] exact_acc;
  logic [WIDTH-1:0] exact_sum;

  assign exact_sum = exact_acc + in_op0 + (in_op1_en ? in_op1 : '0);

  // Exact shadow of acc; mismatch is captured on the last beat and held with the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exact_acc <= '0;
      mismatch  <= 1'b0;
    end else if (flush) begin
      exact_acc <= '0;
      mismatch  <= 1'b0;
    end else if (fire) begin
      exact_acc <= exact_sum;
      if (in_last) mismatch <= (add_sum != exact_sum);
    end else if (state == S_DONE && result_taken) begin
      exact_acc <= '0;
      mismatch  <= 1'b0;
    end
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule
